// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial add/sub family: state encoding,
// default width and the one-bit borrow equation used by the subtractor.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Borrow out of x - y - bin
  function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

endpackage

// File: rtl/sub_serial_full_sub.sv
// One-bit full subtractor with its rippling borrow flop; the difference bit
// is combinational from the current operand bits and the stored borrow.
module serial_full_sub
  import sub_serial_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic x,
  input  logic y,
  output logic d,
  output logic br
);

  logic br_q;
  logic br_d;

  always_comb begin
    br_d = br_q;
    if (clr) begin
      br_d = 1'b0;
    end else if (en) begin
      br_d = fs_borrow(x, y, br_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= 1'b0;
    end else begin
      br_q <= br_d;
    end
  end

  assign d  = x ^ y ^ br_q;
  assign br = br_q;

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: loads a and b, produces a - b LSB first over WIDTH
// cycles, then presents the parallel difference with borrow and overflow.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               in_sub;
  logic               last;
  logic               bit_d;
  logic               bit_br;
  logic [WIDTH:0]     diff_ext;

  assign accept = (state_q == ST_IDLE) && start;
  assign in_sub = (state_q == ST_SUB);
  assign last   = in_sub && (count_q == CNT_W'(WIDTH - 1));

  serial_full_sub u_fs (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (in_sub),
    .x   (a_sh_q[0]),
    .y   (b_sh_q[0]),
    .d   (bit_d),
    .br  (bit_br)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = start ? ST_SUB : ST_IDLE;
      ST_SUB:  state_d = last ? ST_DONE : ST_SUB;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SUB);
    done = (state_q == ST_DONE);
  end

  // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
  assign diff_ext = {bit_d, diff_q};

  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      diff_d  = '0;
      count_d = '0;
    end else if (in_sub) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      diff_d = diff_ext[WIDTH:1];
      if (last) begin
        borrow_d = fs_borrow(a_sh_q[0], b_sh_q[0], bit_br);
        ovf_d    = (a_sh_q[0] ^ b_sh_q[0]) & (bit_d ^ a_sh_q[0]);
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule
